// File: rtl/minimig_ctrlreg_arbiter.sv
// Two-port arbiter for the control-board register bus. It serialises chip-bus (A) and
// OSD/SPI (B) accesses onto one sel/rd/hwr/lwr strobe bus and returns read data with an ack.
module minimig_ctrlreg_arbiter #(
  parameter logic [6:0] BASE_HI = 7'h00,
  parameter bit         FAIR    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_rd,
  input  logic        a_hwr,
  input  logic        a_lwr,
  input  logic [7:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_rd,
  input  logic        b_hwr,
  input  logic        b_lwr,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        sel,
  output logic        rd,
  output logic        hwr,
  output logic        lwr,
  output logic [14:0] addr,
  output logic [15:0] wdata,
  input  logic [15:0] rdata_in,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        rd_lat_q, rd_lat_d;
  logic        sel_q, sel_d;
  logic        rd_q, rd_d;
  logic        hwr_q, hwr_d;
  logic        lwr_q, lwr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        busy_q, busy_d;

  logic        grant_b;
  logic        win_rd;
  logic        win_hwr;
  logic        win_lwr;
  logic [7:0]  win_addr;
  logic [15:0] win_wdata;
  logic        win_is_read;
  logic [15:0] cap_data;

  // A tie goes to whoever was not served last (FAIR) or always to A.
  always_comb begin
    grant_b = 1'b0;
    if (a_req && b_req) begin
      if (FAIR) begin
        grant_b = (last_grant_q == OWN_A);
      end else begin
        grant_b = 1'b0;
      end
    end else begin
      grant_b = b_req;
    end
  end

  always_comb begin
    win_rd    = grant_b ? b_rd    : a_rd;
    win_hwr   = grant_b ? b_hwr   : a_hwr;
    win_lwr   = grant_b ? b_lwr   : a_lwr;
    win_addr  = grant_b ? b_addr  : a_addr;
    win_wdata = grant_b ? b_wdata : a_wdata;
    // Any write strobe wins over rd, so a mixed request is issued as a pure write.
    win_is_read = win_rd & ~(win_hwr | win_lwr);
    cap_data    = rd_lat_q ? rdata_in : 16'h0000;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rd_lat_d     = rd_lat_q;
    sel_d        = 1'b0;
    rd_d         = 1'b0;
    hwr_d        = 1'b0;
    lwr_d        = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          state_d  = ST_STROBE;
          owner_d  = grant_b;
          rd_lat_d = win_is_read;
          sel_d    = 1'b1;
          rd_d     = win_is_read;
          hwr_d    = win_hwr;
          lwr_d    = win_lwr;
          addr_d   = win_addr;
          wdata_d  = win_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        state_d = ST_CAPTURE;
        a_ack_d = (owner_q == OWN_A);
        b_ack_d = (owner_q == OWN_B);
      end
      ST_CAPTURE: begin
        state_d      = ST_HOLD;
        last_grant_d = owner_q;
        if (owner_q == OWN_A) begin
          a_rdata_d = cap_data;
        end else begin
          b_rdata_d = cap_data;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      rd_lat_q     <= 1'b0;
      sel_q        <= 1'b0;
      rd_q         <= 1'b0;
      hwr_q        <= 1'b0;
      lwr_q        <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 16'h0000;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= 16'h0000;
      b_rdata_q    <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_lat_q     <= rd_lat_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      hwr_q        <= hwr_d;
      lwr_q        <= lwr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Downstream read data only arrives in the ack cycle, so it is forwarded while ack is high.
  assign a_rdata = a_ack_q ? cap_data : a_rdata_q;
  assign b_rdata = b_ack_q ? cap_data : b_rdata_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign sel     = sel_q;
  assign rd      = rd_q;
  assign hwr     = hwr_q;
  assign lwr     = lwr_q;
  assign addr    = {BASE_HI, addr_q};
  assign wdata   = wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_minimig_ctrlreg_arbiter.sv
// Scoreboard bench for minimig_ctrlreg_arbiter: a round-robin instance is fully checked,
// a fixed-priority instance with BASE_HI=7'h05 shares the inputs and is checked by ack counts.
module tb_minimig_ctrlreg_arbiter;

  typedef struct {
    logic        rd;
    logic        hwr;
    logic        lwr;
    logic [14:0] addr;
    logic [15:0] wdata;
  } strb_t;

  typedef struct {
    logic        is_b;
    logic [15:0] rdata;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_rd = 1'b0, a_hwr = 1'b0, a_lwr = 1'b0;
  logic [7:0]  a_addr = 8'h00;
  logic [15:0] a_wdata = 16'h0000;
  logic        b_req = 1'b0, b_rd = 1'b0, b_hwr = 1'b0, b_lwr = 1'b0;
  logic [7:0]  b_addr = 8'h00;
  logic [15:0] b_wdata = 16'h0000;

  logic        a_ack, b_ack, sel, rd, hwr, lwr, busy;
  logic [15:0] a_rdata, b_rdata, wdata;
  logic [14:0] addr;
  logic [15:0] rdata_in = 16'h0000;

  logic        a_ack0, b_ack0, sel0, rd0, hwr0, lwr0, busy0;
  logic [15:0] a_rdata0, b_rdata0, wdata0;
  logic [14:0] addr0;
  logic [15:0] rdata_in0 = 16'h0000;

  strb_t strb_q[$];
  ack_t  ack_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int a_ack_cnt = 0, b_ack_cnt = 0, cnt0_a = 0, cnt0_b = 0;
  bit spacing_on = 1'b0;

  always #5 clk = ~clk;

  minimig_ctrlreg_arbiter #(.BASE_HI(7'h00), .FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rd(a_rd), .a_hwr(a_hwr), .a_lwr(a_lwr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_rd(b_rd), .b_hwr(b_hwr), .b_lwr(b_lwr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sel(sel), .rd(rd), .hwr(hwr), .lwr(lwr), .addr(addr), .wdata(wdata),
    .rdata_in(rdata_in), .busy(busy)
  );

  minimig_ctrlreg_arbiter #(.BASE_HI(7'h05), .FAIR(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rd(a_rd), .a_hwr(a_hwr), .a_lwr(a_lwr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack0), .a_rdata(a_rdata0),
    .b_req(b_req), .b_rd(b_rd), .b_hwr(b_hwr), .b_lwr(b_lwr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack0), .b_rdata(b_rdata0),
    .sel(sel0), .rd(rd0), .hwr(hwr0), .lwr(lwr0), .addr(addr0), .wdata(wdata0),
    .rdata_in(rdata_in0), .busy(busy0)
  );

  // Register-file contents returned for a read of a given word address.
  function automatic logic [15:0] resp(input logic [7:0] a);
    return (a == 8'h07) ? 16'h0007 : {a, ~a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdata_in  <= (sel && rd)   ? resp(addr[7:0])  : 16'h0000;
  always @(posedge clk) rdata_in0 <= (sel0 && rd0) ? resp(addr0[7:0]) : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_b, input logic r, input logic h, input logic l,
                      input logic [7:0] ad, input logic [15:0] wd, input logic [15:0] rdv);
    strb_t s;
    ack_t  e;
    s.rd = r; s.hwr = h; s.lwr = l; s.addr = {7'h00, ad}; s.wdata = wd;
    strb_q.push_back(s);
    e.is_b = is_b; e.rdata = rdv;
    ack_q.push_back(e);
  endtask

  // Returns one clock after the awaited ack, i.e. in the HOLD cycle.
  task automatic wait_acks(input int ta, input int tb);
    int n = 0;
    while ((a_ack_cnt < ta || b_ack_cnt < tb) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("ack_wait_timeout", 32'((a_ack_cnt >= ta) && (b_ack_cnt >= tb)), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    strb_t s;
    ack_t  e;
    int    sel_cyc = -10;
    int    prev_ack_cyc = 0;
    bit    in_burst = 1'b0;
    logic [15:0] hold_a = 16'h0000;
    logic [15:0] hold_b = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_a = 16'h0000;
        hold_b = 16'h0000;
        in_burst = 1'b0;
      end else begin
        if (sel) begin
          if (strb_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            s = strb_q.pop_front();
            check("strobes_rd_hwr_lwr", {29'd0, rd, hwr, lwr}, {29'd0, s.rd, s.hwr, s.lwr});
            check("addr", {17'd0, addr}, {17'd0, s.addr});
            check("wdata", {16'd0, wdata}, {16'd0, s.wdata});
          end
          sel_cyc = cyc;
        end
        if (a_ack || b_ack) begin
          if (a_ack) a_ack_cnt++;
          if (b_ack) b_ack_cnt++;
          check("ack_after_strobe", cyc, sel_cyc + 1);
          if (ack_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = ack_q.pop_front();
            check("ack_owner", {30'd0, a_ack, b_ack}, e.is_b ? 32'd1 : 32'd2);
            if (e.is_b) begin
              check("b_rdata", {16'd0, b_rdata}, {16'd0, e.rdata});
              check("a_rdata_hold", {16'd0, a_rdata}, {16'd0, hold_a});
              hold_b = e.rdata;
            end else begin
              check("a_rdata", {16'd0, a_rdata}, {16'd0, e.rdata});
              check("b_rdata_hold", {16'd0, b_rdata}, {16'd0, hold_b});
              hold_a = e.rdata;
            end
          end
          if (spacing_on && in_burst) check("ack_spacing", cyc - prev_ack_cyc, 32'd4);
          in_burst = spacing_on;
          prev_ack_cyc = cyc;
        end
        if (!spacing_on) in_burst = 1'b0;
        if (a_ack0) cnt0_a++;
        if (b_ack0) cnt0_b++;
        if (sel0) check("base_hi_addr0", {25'd0, addr0[14:8]}, 32'h05);
      end
    end
  end

  initial begin : stimulus
    int ta = 0;
    int tb = 0;
    int base0a, base0b, acnt_rst;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {25'd0, sel, rd, hwr, lwr, a_ack, b_ack, busy}, 32'd0);
    check("rst_addr", {17'd0, addr}, 32'h0000);
    check("rst_wdata_rdata", {wdata, a_rdata | b_rdata}, 32'd0);
    check("rst_dut0_strobes", {25'd0, sel0, rd0, hwr0, lwr0, a_ack0, b_ack0, busy0}, 32'd0);
    check("rst_dut0_addr", {17'd0, addr0}, 32'h0500);
    check("rst_dut0_data", {wdata0, a_rdata0 | b_rdata0}, 32'd0);
    rst = 1'b0;

    // Lone A read: strobe the cycle after IDLE sees the request, ack one cycle later.
    @(posedge clk); #1;
    a_req = 1'b1; a_rd = 1'b1; a_addr = 8'h07; a_wdata = 16'h1111;
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 16'h1111, 16'h0007);
    @(negedge clk);
    check("idle_no_sel", {30'd0, sel, busy}, 32'd0);
    @(negedge clk);
    check("strobe_sel_busy", {30'd0, sel, busy}, 32'd3);
    ta++;
    wait_acks(ta, tb);
    a_req = 1'b0; a_rd = 1'b0;

    // Lone B lower-byte write.
    @(posedge clk); #1;
    b_req = 1'b1; b_lwr = 1'b1; b_addr = 8'h08; b_wdata = 16'h0040;
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 16'h0040, 16'h0000);
    tb++;
    wait_acks(ta, tb);
    b_req = 1'b0; b_lwr = 1'b0;

    // A with no strobes at all: sel-only cycle, rdata 0.
    @(posedge clk); #1;
    a_req = 1'b1; a_addr = 8'h11; a_wdata = 16'h2222;
    push(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 16'h2222, 16'h0000);
    ta++;
    wait_acks(ta, tb);
    a_req = 1'b0;

    // rd+lwr issued as a write; A drops req and changes content after the grant;
    // B requests only while the arbiter is busy and is never serviced.
    @(posedge clk); #1;
    a_req = 1'b1; a_rd = 1'b1; a_lwr = 1'b1; a_addr = 8'h22; a_wdata = 16'h1234;
    push(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 16'h1234, 16'h0000);
    @(posedge clk); #1;
    a_req = 1'b0; a_addr = 8'h33; a_wdata = 16'hFFFF;
    b_req = 1'b1; b_rd = 1'b1; b_addr = 8'h99;
    @(posedge clk); #1;
    b_req = 1'b0; b_rd = 1'b0;
    ta++;
    wait_acks(ta, tb);
    a_rd = 1'b0; a_lwr = 1'b0;
    repeat (8) @(negedge clk);
    check("dropped_req_acked_once", a_ack_cnt, 32'd3);
    check("ungranted_b_not_served", b_ack_cnt, 32'd1);

    // Both held: round-robin alternates starting with B (A was served last);
    // the fixed-priority instance serves only A.
    @(posedge clk); #1;
    base0a = cnt0_a; base0b = cnt0_b;
    spacing_on = 1'b1;
    a_req = 1'b1; a_rd = 1'b1; a_addr = 8'h44; a_wdata = 16'h0000;
    b_req = 1'b1; b_hwr = 1'b1; b_addr = 8'h55; b_wdata = 16'hCAFE;
    push(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 16'hCAFE, 16'h0000);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 16'h0000, 16'h44BB);
    push(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 16'hCAFE, 16'h0000);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 16'h0000, 16'h44BB);
    ta += 2; tb += 2;
    wait_acks(ta, tb);
    a_req = 1'b0; b_req = 1'b0; a_rd = 1'b0; b_hwr = 1'b0;
    spacing_on = 1'b0;
    check("fixed_prio_a_grants", cnt0_a - base0a, 32'd4);
    check("fixed_prio_b_grants", cnt0_b - base0b, 32'd0);

    // Reset during STROBE aborts without ack; afterwards A wins the tie, then B.
    @(posedge clk); #1;
    a_req = 1'b1; a_rd = 1'b1; a_addr = 8'h66;
    @(posedge clk); #1;
    check("abort_pre_sel_rd", {30'd0, sel, rd}, 32'd3);
    acnt_rst = a_ack_cnt;
    #1 rst = 1'b1;
    #1;
    check("abort_strobes_drop", {25'd0, sel, rd, hwr, lwr, a_ack, b_ack, busy}, 32'd0);
    check("abort_dut0_sel", {31'd0, sel0}, 32'd0);
    b_req = 1'b1; b_lwr = 1'b1; b_addr = 8'h77; b_wdata = 16'h0F0F;
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 16'h0000, 16'h6699);
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 16'h0F0F, 16'h0000);
    @(posedge clk); #3;
    rst = 1'b0;
    check("abort_no_ack", a_ack_cnt, acnt_rst);
    ta++;
    wait_acks(ta, tb);
    a_req = 1'b0; a_rd = 1'b0;
    tb++;
    wait_acks(ta, tb);
    b_req = 1'b0; b_lwr = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_strobes_left", strb_q.size(), 32'd0);
    check("sb_acks_left", ack_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/minimig_ctrlreg_arbiter.md
Name: minimig_ctrlreg_arbiter

Overview:
- Two-port arbiter for the control-board register bus (MIDI enable, drive-sound enables, audio-overflow latch, capability word, volume registers).
- Requester A is the Amiga-side chip-bus decoder; requester B is the host/OSD SPI register interface.
- Serialises their accesses onto the single sel/rd/hwr/lwr strobe bus, captures registered read data and returns it to the owning requester with a one-cycle ack.

Parameters:
- BASE_HI, 7'h00, upper address bits [15:9] driven on the downstream addr.
- FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  requester A access request; held until a_ack
- a_rd  in  1  A read
- a_hwr  in  1  A upper-byte write
- a_lwr  in  1  A lower-byte write
- a_addr  in  8  A word address [8:1]
- a_wdata  in  16  A write data
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  16  A read data, valid while a_ack=1
- b_req, b_rd, b_hwr, b_lwr, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B
- sel  out  1  downstream select strobe
- rd  out  1  downstream read strobe
- hwr  out  1  downstream upper-byte write strobe
- lwr  out  1  downstream lower-byte write strobe
- addr  out  15  downstream address [15:1] = {BASE_HI, granted addr}
- wdata  out  16  downstream write data
- rdata_in  in  16  downstream read data; registered, valid one cycle after the sel&rd cycle, 0 otherwise
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values: sel, rd, hwr, lwr = 0. addr = {BASE_HI, 8'h00}. wdata = 0. a_ack, b_ack = 0. a_rdata, b_rdata = 0. busy = 0. State = IDLE. last_grant = B, so A wins the first tie.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction immediately, with no ack; strobes drop in the same cycle.
- FSM states:
  - IDLE: if any req is high, select a winner, latch its rd/hwr/lwr/addr/wdata into registers, record the owner, go to STROBE.
  - STROBE: exactly one cycle. Drive sel=1 plus the latched rd/hwr/lwr; go to CAPTURE.
  - CAPTURE: all strobes 0. Copy rdata_in into the owner's rdata register (0 for writes). Pulse the owner's ack for this one cycle. Update last_grant to the owner. Go to HOLD.
  - HOLD: one cycle. Lets the owner deassert req before re-arbitration; go to IDLE.
- Latency: request first seen high in IDLE at cycle N → strobe in N+1 → ack and rdata in N+2 → next grant can be taken at N+4. Peak throughput is one access per 4 cycles.
- Arbitration:
  - FAIR=1: the requester that did not receive last_grant wins a tie.
  - FAIR=0: A always wins a tie.
  - A lone requester always wins.
- Request content is sampled only in IDLE. Changes to addr/data after the grant are ignored until ack.
- A req that drops before it is granted is never serviced. A req that drops after the grant still completes and still acks.
- Conflicting strobes:
  - rd together with hwr/lwr: treated as a write, rd suppressed downstream.
  - No rd/hwr/lwr at all: a sel-only cycle is issued, ack is given, rdata = 0.
- Non-owner rdata holds its previous value. Each rdata register updates only on its own ack cycle.
- busy = (state != IDLE).

Test Plan:
- Reset released, a_req=1, a_rd=1, a_addr=8'h07, rdata_in=16'h0007 in the cycle after strobe → sel=rd=1 in N+1 with addr=15'h0007; a_ack=1 and a_rdata=16'h0007 in N+2; no b_ack.
- b_req write: b_lwr=1, b_addr=8'h08, b_wdata=16'h0040 → single cycle sel=lwr=1, addr=15'h0008, wdata=16'h0040; b_ack in the next cycle; b_rdata=0.
- a_req and b_req held high continuously, FAIR=1 → grants alternate A,B,A,B, with one ack every 4 cycles. With FAIR=0 → all grants go to A.
- Simultaneous first request after reset → A granted first. B's request stays pending and is granted at the next IDLE.
- rst asserted during STROBE → sel/rd/lwr/hwr = 0 asynchronously, no ack. After release, a still-high req is serviced from IDLE.
- a_rd=1 and a_lwr=1 together → downstream lwr=1, rd=0. a_req dropped while in STROBE → a_ack still pulses exactly once.
